// File: rtl/ethhelper_stream_pkg.sv
// Shared stream definitions for the snoop mux: channel STREAM_TYPE codes, default widths and mux FSM states.
package ethhelper_stream_pkg;

  localparam int STREAM_TYPE_WIDTH = 3;

  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_AW = 3'd0;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_W  = 3'd1;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_B  = 3'd2;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_AR = 3'd3;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_R  = 3'd4;

  localparam int DEFAULT_NUM_SRC    = 5;
  localparam int DEFAULT_DATA_WIDTH = 128;
  localparam int DEFAULT_LEN_WIDTH  = 6;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } mux_state_t;

  // Index after idx, wrapping n-1 back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 32'sd1 >= n) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/axi_snoop_stream_mux_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping, as one-hot plus index.
module rr_arbiter #(
  parameter int NUM_SRC = 5,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Scan candidates in rotation order starting at the pointer
  always_comb begin
    int               sum_s;
    int               cand_s;
    logic [IDX_W-1:0] c_s;
    logic             hit_s;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      sum_s      = int'(ptr_i) + k;
      cand_s     = (sum_s >= NUM_SRC) ? sum_s - NUM_SRC : sum_s;
      c_s        = IDX_W'(cand_s);
      hit_s      = ~any_o & req_i[c_s];
      gnt_o[c_s] = gnt_o[c_s] | hit_s;
      idx_o      = hit_s ? c_s : idx_o;
      any_o      = any_o | hit_s;
    end
  end

endmodule

// File: rtl/axi_snoop_stream_mux.sv
// Round-robin serializer of snoop submodule beats onto one AXI4-Stream master, grant held per transaction.
// Optional m_axis_tuser (granted source index) enabled by AXI_SNOOP_STREAM_MUX_TUSER_EN.
module axi_snoop_stream_mux
  import ethhelper_stream_pkg::*;
#(
  parameter int NUM_SRC    = DEFAULT_NUM_SRC,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NUM_SRC-1:0]              src_valid,
  input  logic [NUM_SRC-1:0]              src_in_progress,
  input  logic [NUM_SRC-1:0]              src_last,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
  input  logic [NUM_SRC*LEN_WIDTH-1:0]    src_length,
  output logic [NUM_SRC-1:0]              src_ready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
`ifdef AXI_SNOOP_STREAM_MUX_TUSER_EN
  output logic [$clog2(NUM_SRC)-1:0]      m_axis_tuser,
`endif
  output logic                            len_err
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  mux_state_t             state_q;
  logic [NUM_SRC-1:0]     grant_q;
  logic [IDX_W-1:0]       gidx_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [LEN_WIDTH-1:0]   beat_cnt_q;
  logic [DATA_WIDTH-1:0]  tdata_q;
  logic                   tvalid_q;
  logic                   tlast_q;
  logic                   len_err_q;

  logic [NUM_SRC-1:0]     arb_gnt_s;
  logic [IDX_W-1:0]       arb_idx_s;
  logic                   arb_any_s;
  logic                   out_free_s;
  logic                   accept_s;
  logic [DATA_WIDTH-1:0]  sel_data_s;
  logic                   sel_last_s;
  logic [LEN_WIDTH-1:0]   sel_len_s;
  logic [LEN_WIDTH:0]     beat_cnt_inc_s;
  logic                   len_bad_s;
  logic [LEN_WIDTH-1:0]   beat_cnt_d;
  logic [IDX_W-1:0]       rr_ptr_d;
  logic                   unused_in_progress_s;

  rr_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i (src_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt_s),
    .idx_o (arb_idx_s),
    .any_o (arb_any_s)
  );

  // The grant only ends on an accepted last beat, so in-progress carries no extra information here.
  assign unused_in_progress_s = ^src_in_progress;

  assign out_free_s = ~tvalid_q | m_axis_tready;
  assign src_ready  = grant_q & {NUM_SRC{out_free_s}};
  assign accept_s   = |(src_ready & src_valid);

  assign sel_data_s = src_data[gidx_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_last_s = src_last[gidx_q];
  assign sel_len_s  = src_length[gidx_q*LEN_WIDTH +: LEN_WIDTH];

  // One extra bit so a saturated counter can never alias a legal declared length.
  assign beat_cnt_inc_s = {1'b0, beat_cnt_q} + {{LEN_WIDTH{1'b0}}, 1'b1};
  assign len_bad_s      = (beat_cnt_inc_s != {1'b0, sel_len_s});
  assign beat_cnt_d     = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  assign rr_ptr_d       = IDX_W'(wrap_inc(int'(gidx_q), NUM_SRC));

  // Arbitration/lock FSM, rotation pointer, beat counter and sticky length error
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_any_s) begin
            grant_q <= arb_gnt_s;
            gidx_q  <= arb_idx_s;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept_s) begin
            if (sel_last_s) begin
              grant_q    <= '0;
              rr_ptr_q   <= rr_ptr_d;
              beat_cnt_q <= '0;
              state_q    <= IDLE;
              if (len_bad_s) begin
                len_err_q <= 1'b1;
              end
            end else begin
              beat_cnt_q <= beat_cnt_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

`ifdef AXI_SNOOP_STREAM_MUX_TUSER_EN
  logic [IDX_W-1:0] tuser_q;
  assign m_axis_tuser = tuser_q;
`endif

  // Output register: refill on an accepted beat, otherwise drain when the sink takes it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
`ifdef AXI_SNOOP_STREAM_MUX_TUSER_EN
      tuser_q  <= '0;
`endif
    end else if (accept_s) begin
      tdata_q  <= sel_data_s;
      tvalid_q <= 1'b1;
      tlast_q  <= sel_last_s;
`ifdef AXI_SNOOP_STREAM_MUX_TUSER_EN
      tuser_q  <= gidx_q;
`endif
    end else if (m_axis_tready) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign len_err       = len_err_q;

endmodule
